// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU sequencer/arbiter.
package fpu_arb_pkg;

  localparam int MDU_OP_LEN  = 5;
  localparam int TMO_CYC_DEF = 256;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [MDU_OP_LEN-1:0] op;
    logic                  len_64;
    logic [63:0]           src1;
    logic [63:0]           src2;
  } fpu_req_t;

endpackage

// File: rtl/fpu_arb_chk.sv
// Protocol checker for fpu_arb: one-hot response and isolated trigger pulses.
module fpu_arb_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] rsp_valid,
  input logic       fpu_trig
);

  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_trig_single: assert property (@(posedge clk) disable iff (rst) fpu_trig |=> !fpu_trig);

endmodule

// File: rtl/fpu_arb_rr.sv
// Two-way round-robin grant; ptr names the winner when both requesters are valid.
module fpu_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] gnt
);

  // grant selection, gated by advance so no grant is offered while busy
  always_comb begin
    gnt = 2'b00;
    if (!advance) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/fpu_arb.sv
// Sequences the shared multi-cycle FPU and arbitrates it between the execute
// stage (requester 0) and the debug port (requester 1); one op in flight.
module fpu_arb
  import fpu_arb_pkg::*;
#(
  parameter int OP_W    = MDU_OP_LEN,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][OP_W-1:0] req_op,
  input  logic [1:0]           req_len_64,
  input  logic [1:0][63:0]     req_src1,
  input  logic [1:0][63:0]     req_src2,
  input  logic [1:0]           req_flush,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 fpu_trig,
  output logic                 fpu_len_64,
  output logic [OP_W-1:0]      fpu_op,
  output logic [63:0]          fpu_src1,
  output logic [63:0]          fpu_src2,
  output logic                 fpu_flush,
  input  logic [63:0]          fpu_out,
  input  logic                 fpu_okay
);

  state_e           state_r, state_s;
  logic             rr_ptr_r, owner_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       gnt_s, avail_s;
  logic             idle_s, own_flush_s, tmo_s;
  logic             accept_s, cap_ok_s, cap_tmo_s;

  // a requester flushing this cycle must not be granted
  assign avail_s     = req_valid & ~req_flush;
  assign idle_s      = (state_r == IDLE);
  assign own_flush_s = req_flush[owner_r];
  assign tmo_s       = (state_r == WAIT) && (cnt_r == CNT_W'(TMO_CYC - 1));

  fpu_arb_rr u_rr (
    .req     (avail_s),
    .ptr     (rr_ptr_r),
    .advance (idle_s),
    .gnt     (gnt_s)
  );

  assign req_ready = gnt_s;
  assign fpu_trig  = (state_r == ISSUE);
  assign rsp_valid = (state_r == RESP) ? (owner_r ? 2'b10 : 2'b01) : 2'b00;

  // next-state, capture strobes and the abort pulse to the FPU
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    cap_ok_s  = 1'b0;
    cap_tmo_s = 1'b0;
    fpu_flush = 1'b0;
    case (state_r)
      IDLE: begin
        if (|gnt_s) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (own_flush_s) begin
          fpu_flush = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        // owner flush beats a same-cycle okay; okay beats the watchdog
        if (own_flush_s) begin
          fpu_flush = 1'b1;
          state_s   = IDLE;
        end else if (fpu_okay) begin
          cap_ok_s = 1'b1;
          state_s  = RESP;
        end else if (tmo_s) begin
          fpu_flush = 1'b1;
          cap_tmo_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (own_flush_s || rsp_ready[owner_r]) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // operand, ownership, watchdog and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= 1'b0;
      owner_r    <= 1'b0;
      cnt_r      <= '0;
      fpu_op     <= '0;
      fpu_len_64 <= 1'b0;
      fpu_src1   <= 64'd0;
      fpu_src2   <= 64'd0;
      rsp_data   <= 64'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept_s) begin
        owner_r    <= gnt_s[1];
        rr_ptr_r   <= ~gnt_s[1];
        fpu_op     <= req_op[gnt_s[1]];
        fpu_len_64 <= req_len_64[gnt_s[1]];
        fpu_src1   <= req_src1[gnt_s[1]];
        fpu_src2   <= req_src2[gnt_s[1]];
      end
      if (state_r == ISSUE) begin
        cnt_r <= '0;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (cap_ok_s) begin
        rsp_data <= fpu_out;
        rsp_err  <= 1'b0;
      end else if (cap_tmo_s) begin
        rsp_data <= 64'd0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_arb.sv
// Directed bench for fpu_arb: idle grant table plus hand-written sequences.
module tb_fpu_arb;
  import fpu_arb_pkg::*;

  localparam int OP_W = MDU_OP_LEN;
  localparam logic [OP_W-1:0] FADD = 5'd1;
  localparam logic [OP_W-1:0] FMUL = 5'd2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid, req_ready, req_len_64, req_flush;
  logic [1:0][OP_W-1:0] req_op;
  logic [1:0][63:0]     req_src1, req_src2;
  logic [1:0]           rsp_valid, rsp_ready;
  logic [63:0]          rsp_data, fpu_src1, fpu_src2, fpu_out;
  logic                 rsp_err, fpu_trig, fpu_len_64, fpu_flush, fpu_okay;
  logic [OP_W-1:0]      fpu_op;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] flush;
    logic [1:0] exp_ready;
  } idle_vec_t;

  idle_vec_t iv[8];
  fpu_req_t  rq[2];

  fpu_arb #(.OP_W(OP_W), .TMO_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len_64(req_len_64), .req_src1(req_src1), .req_src2(req_src2),
    .req_flush(req_flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_trig(fpu_trig), .fpu_len_64(fpu_len_64),
    .fpu_op(fpu_op), .fpu_src1(fpu_src1), .fpu_src2(fpu_src2), .fpu_flush(fpu_flush),
    .fpu_out(fpu_out), .fpu_okay(fpu_okay)
  );

  fpu_arb_chk u_chk (.clk(clk), .rst(rst), .rsp_valid(rsp_valid), .fpu_trig(fpu_trig));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int r, input fpu_req_t q);
    req_op[r]     = q.op;
    req_len_64[r] = q.len_64;
    req_src1[r]   = q.src1;
    req_src2[r]   = q.src2;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_flush = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_len_64 = 2'b00; req_src1 = '0; req_src2 = '0;
    fpu_out = 64'd0; fpu_okay = 1'b0;
    iv[0] = '{2'b00, 2'b00, 2'b00};
    iv[1] = '{2'b01, 2'b00, 2'b01};
    iv[2] = '{2'b10, 2'b00, 2'b10};
    iv[3] = '{2'b11, 2'b00, 2'b01};
    iv[4] = '{2'b11, 2'b01, 2'b10};
    iv[5] = '{2'b11, 2'b11, 2'b00};
    iv[6] = '{2'b01, 2'b01, 2'b00};
    iv[7] = '{2'b10, 2'b01, 2'b10};
    rq[0] = '{FADD, 1'b1, 64'h1111_0000_0000_0000, 64'h1111_0000_0000_0001};
    rq[1] = '{FMUL, 1'b0, 64'h2222_0000_0000_0000, 64'h2222_0000_0000_0001};

    #12;
    chk("rst_trig", 64'(fpu_trig), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fpu_src1", fpu_src1, 64'd0);
    chk("rst_flush", 64'(fpu_flush), 64'd0);
    step();

    // idle grant table, rr_ptr still 0
    for (int i = 0; i < 8; i++) begin
      req_valid = iv[i].valid;
      req_flush = iv[i].flush;
      #1;
      chk($sformatf("idle_ready[%0d]", i), 64'(req_ready), 64'(iv[i].exp_ready));
    end
    req_valid = 2'b00; req_flush = 2'b00;
    step();

    // contention: both held valid, FPU answers at trig+2
    drive_op(0, rq[0]);
    drive_op(1, rq[1]);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont_ready[%0d]", k), 64'(req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
      step();
      #1;
      chk($sformatf("cont_trig[%0d]", k), 64'(fpu_trig), 64'd1);
      chk($sformatf("cont_op[%0d]", k), 64'(fpu_op), 64'(rq[k % 2].op));
      chk($sformatf("cont_src1[%0d]", k), fpu_src1, rq[k % 2].src1);
      chk($sformatf("cont_busy_ready[%0d]", k), 64'(req_ready), 64'd0);
      step();
      step();
      fpu_okay = 1'b1; fpu_out = 64'hC0DE_0000 + 64'(k);
      step();
      fpu_okay = 1'b0;
      #1;
      chk($sformatf("cont_rsp_valid[%0d]", k), 64'(rsp_valid), (k % 2 == 1) ? 64'd2 : 64'd1);
      chk($sformatf("cont_rsp_data[%0d]", k), rsp_data, 64'hC0DE_0000 + 64'(k));
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    step();

    // single FADD op from requester 0, okay at trig+3
    drive_op(0, '{FADD, 1'b1, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000});
    req_valid = 2'b01;
    #1;
    chk("single_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    #1;
    chk("single_trig", 64'(fpu_trig), 64'd1);
    chk("single_op", 64'(fpu_op), 64'(FADD));
    chk("single_src2", fpu_src2, 64'h3FF0_0000_0000_0000);
    chk("single_len", 64'(fpu_len_64), 64'd1);
    step();
    chk("single_trig_once", 64'(fpu_trig), 64'd0);
    step();
    step();
    fpu_okay = 1'b1; fpu_out = 64'h4000_0000_0000_0000;
    #1;
    chk("single_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    fpu_okay = 1'b0;
    #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_data", rsp_data, 64'h4000_0000_0000_0000);
    chk("single_rsp_err", 64'(rsp_err), 64'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    #1;
    chk("single_rsp_drop", 64'(rsp_valid), 64'd0);

    // watchdog: no okay, abort 8 cycles after trig
    req_valid = 2'b01;
    #1;
    chk("tmo_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    #1;
    chk("tmo_trig", 64'(fpu_trig), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("tmo_flush[%0d]", i), 64'(fpu_flush), 64'(i == 8));
    end
    step();
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
    chk("tmo_rsp_data", rsp_data, 64'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;

    // backpressure on requester 0 while requester 1 waits
    req_valid = 2'b01;
    #1;
    chk("bp_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    step();
    fpu_okay = 1'b1; fpu_out = 64'hBEEF;
    step();
    fpu_okay = 1'b0; fpu_out = 64'd0; req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_valid[%0d]", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_data[%0d]", i), rsp_data, 64'hBEEF);
      chk($sformatf("bp_ready_hold[%0d]", i), 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp_ready_last", 64'(req_ready), 64'd0);
    step();
    rsp_ready = 2'b00;
    chk("bp_ready_after", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    chk("bp_src1_owner1", fpu_src1, rq[1].src1);

    // reset asserted mid-WAIT
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_src1", fpu_src1, 64'd0);
    chk("mid_rst_op", 64'(fpu_op), 64'd0);
    chk("mid_rst_flush", 64'(fpu_flush), 64'd0);
    chk("mid_rst_data", rsp_data, 64'd0);
    step();
    rst = 1'b0;
    fpu_okay = 1'b1; fpu_out = 64'h1234;
    step();
    fpu_okay = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_no_rsp[%0d]", i), 64'(rsp_valid), 64'd0);
      step();
    end

    // flush of requester 1 in WAIT with coincident okay
    req_valid = 2'b10;
    #1;
    chk("fl_ready", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    #1;
    chk("fl_trig", 64'(fpu_trig), 64'd1);
    step();
    req_flush = 2'b01;
    #1;
    chk("fl_nonowner", 64'(fpu_flush), 64'd0);
    step();
    req_flush = 2'b10; fpu_okay = 1'b1;
    #1;
    chk("fl_flush", 64'(fpu_flush), 64'd1);
    step();
    req_flush = 2'b00; fpu_okay = 1'b0;
    #1;
    chk("fl_flush_once", 64'(fpu_flush), 64'd0);
    chk("fl_no_rsp", 64'(rsp_valid), 64'd0);
    req_valid = 2'b10;
    #1;
    chk("fl_ready_back", 64'(req_ready), 64'd2);
    req_valid = 2'b00;
    step();

    // flush in the trig cycle
    req_valid = 2'b01;
    #1;
    chk("flt_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00; req_flush = 2'b01;
    #1;
    chk("flt_trig", 64'(fpu_trig), 64'd1);
    chk("flt_flush", 64'(fpu_flush), 64'd1);
    step();
    req_flush = 2'b00;
    req_valid = 2'b10;
    #1;
    chk("flt_idle_ready", 64'(req_ready), 64'd2);
    chk("flt_no_rsp", 64'(rsp_valid), 64'd0);
    req_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
